// File: rtl/pci_txn_queue.sv
// Transaction queue for a PCI-style initiator: buffers {rw, addr, data, be}
// entries and runs the request/grant/devsel handshake for the head entry.
module pci_txn_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        push_rw,
    input  logic [31:0] push_addr,
    input  logic [31:0] push_data,
    input  logic [3:0]  push_be,
    output logic        full,
    output logic        empty,
    output logic [3:0]  count,
    input  logic        grant,
    input  logic        devsel,
    input  logic        tready,
    output logic        force_req,
    output logic        rw,
    output logic [31:0] contact_address,
    output logic [31:0] data,
    output logic [3:0]  be,
    output logic        busy,
    output logic        done,
    output logic        abort
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    // IDLE: latch head | REQ: await grant | WAIT_DEV: await target, timed
    // XFER: data phase | RELEASE: one idle cycle before the next request
    typedef enum logic [2:0] {IDLE, REQ, WAIT_DEV, XFER, RELEASE} state_t;

    state_t          state;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [TW-1:0]   timer;
    logic            mem_rw   [DEPTH];
    logic [31:0]     mem_addr [DEPTH];
    logic [31:0]     mem_data [DEPTH];
    logic [3:0]      mem_be   [DEPTH];
    logic            responded;
    logic            pop;
    logic            push_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full      = (count == 4'(DEPTH));
    assign empty     = (count == 4'd0);
    assign responded = !devsel && !tready;
    assign pop       = (state == XFER) ||
                       (state == WAIT_DEV && !responded && timer == TW'(TIMEOUT - 1));
    // A full queue still takes a push in the cycle its head leaves.
    assign push_ok   = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem_rw[wr_ptr]   <= push_rw;
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
            mem_be[wr_ptr]   <= push_be;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            timer           <= '0;
            force_req       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            abort           <= 1'b0;
            rw              <= 1'b0;
            contact_address <= '0;
            data            <= '0;
            be              <= '0;
        end else begin
            done  <= 1'b0;
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    force_req <= 1'b0;
                    if (!empty) begin
                        rw              <= mem_rw[rd_ptr];
                        contact_address <= mem_addr[rd_ptr];
                        data            <= mem_data[rd_ptr];
                        be              <= mem_be[rd_ptr];
                        busy            <= 1'b1;
                        state           <= REQ;
                    end
                end
                REQ: begin
                    force_req <= 1'b1;
                    if (!grant) begin
                        timer <= '0;
                        state <= WAIT_DEV;
                    end
                end
                WAIT_DEV: begin
                    if (responded) begin
                        state <= XFER;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        abort     <= 1'b1;
                        force_req <= 1'b0;
                        state     <= RELEASE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                XFER: begin
                    done      <= 1'b1;
                    force_req <= 1'b0;
                    state     <= RELEASE;
                end
                RELEASE: begin
                    force_req <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pci_txn_queue.sv
// Self-checking bench for pci_txn_queue: a queue model of the entries plus
// bench-chosen target response delays predict every pulse and head value.
module tb_pci_txn_queue;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, push, push_rw, full, empty, grant, devsel, tready;
    logic [31:0] push_addr, push_data, contact_address, data;
    logic [3:0]  push_be, count, be;
    logic        force_req, rw, busy, done, abort;

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t mq[$];

    pci_txn_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .push(push), .push_rw(push_rw),
        .push_addr(push_addr), .push_data(push_data), .push_be(push_be),
        .full(full), .empty(empty), .count(count),
        .grant(grant), .devsel(devsel), .tready(tready),
        .force_req(force_req), .rw(rw), .contact_address(contact_address),
        .data(data), .be(be), .busy(busy), .done(done), .abort(abort)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic ent_t rand_ent();
        ent_t e;
        e.rw   = 1'($urandom_range(0, 1));
        e.addr = $urandom;
        e.data = $urandom;
        e.be   = 4'($urandom_range(0, 15));
        return e;
    endfunction

    function automatic bit coin(input int mode);
        return (mode == 1) && ($urandom_range(0, 99) < 30);
    endfunction

    // One clock with optional push; do_pop is the bench's own prediction.
    task automatic tick(input bit do_push, input bit do_pop, input ent_t e);
        bit acc;
        push = do_push; push_rw = e.rw; push_addr = e.addr;
        push_data = e.data; push_be = e.be;
        @(posedge clk);
        acc = do_push && (mq.size() < DEPTH || do_pop);
        if (do_pop && mq.size() > 0) void'(mq.pop_front());
        if (acc) mq.push_back(e);
        #1;
        push = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; push = 1'b0;
        grant = 1'b1; devsel = 1'b1; tready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete();
    endtask

    // Serve the head: target answers d cycles into WAIT_DEV (d >= TIMEOUT: never).
    // mode 0: no pushes, 1: random pushes, 2: push only on the pop edge.
    task automatic serve(input int d, input int mode);
        ent_t hd;
        bit   got, resp;
        got = 1'b0; resp = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (force_req === 1'b1) begin got = 1'b1; break; end
            tick(coin(mode), 1'b0, rand_ent());
            n_checks++;
            if (done !== 1'b0 || abort !== 1'b0) begin
                n_fail++; $display("FAIL idle_pulse: done=%b abort=%b expected 0", done, abort);
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++; $display("FAIL req_wait: force_req=%b expected 1 within 20 cycles", force_req);
            return;
        end
        hd = mq[0];
        n_checks++;
        if ({rw, contact_address, data, be} !== hd) begin
            n_fail++; $display("FAIL head_latch: got %h expected %h", {rw, contact_address, data, be}, hd);
        end
        grant = 1'b0;
        tick(coin(mode), 1'b0, rand_ent());
        grant = 1'b1;
        for (int k = 0; k < TIMEOUT; k++) begin
            resp = (k == d);
            devsel = !resp; tready = !resp;
            if (resp || k == TIMEOUT - 1) break;
            tick(coin(mode), 1'b0, rand_ent());
            n_checks++;
            if (force_req !== 1'b1 || done !== 1'b0 || abort !== 1'b0 ||
                {rw, contact_address, data, be} !== hd || count !== 4'(mq.size())) begin
                n_fail++;
                $display("FAIL wait_dev: fr=%b done=%b abort=%b head=%h count=%0d expected fr=1 pulses=0 head=%h count=%0d",
                         force_req, done, abort, {rw, contact_address, data, be}, count, hd, mq.size());
            end
        end
        if (resp) begin
            tick(coin(mode), 1'b0, rand_ent());
            devsel = 1'b1; tready = 1'b1;
            n_checks++;
            if (force_req !== 1'b1 || done !== 1'b0 || {rw, contact_address} !== {hd.rw, hd.addr}) begin
                n_fail++; $display("FAIL xfer: fr=%b done=%b expected fr=1 done=0", force_req, done);
            end
            tick(mode == 2 || coin(mode), 1'b1, rand_ent());
            n_checks++;
            if (done !== 1'b1 || abort !== 1'b0) begin
                n_fail++; $display("FAIL done_pulse: done=%b abort=%b expected 1 0 (d=%0d)", done, abort, d);
            end
        end else begin
            tick(mode == 2 || coin(mode), 1'b1, rand_ent());
            n_checks++;
            if (abort !== 1'b1 || done !== 1'b0) begin
                n_fail++; $display("FAIL abort_pulse: abort=%b done=%b expected 1 0 (d=%0d)", abort, done, d);
            end
        end
        devsel = 1'b1; tready = 1'b1;
        n_checks++;
        if (force_req !== 1'b0 || busy !== 1'b1 || {rw, contact_address, data, be} !== hd ||
            count !== 4'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
            n_fail++;
            $display("FAIL release: fr=%b busy=%b count=%0d empty=%b full=%b expected fr=0 busy=1 count=%0d",
                     force_req, busy, count, empty, full, mq.size());
        end
        tick(coin(mode), 1'b0, rand_ent());
        n_checks++;
        if (busy !== 1'b0 || force_req !== 1'b0 || done !== 1'b0 || abort !== 1'b0 ||
            {rw, contact_address, data, be} !== hd || count !== 4'(mq.size())) begin
            n_fail++;
            $display("FAIL back_idle: busy=%b fr=%b done=%b abort=%b count=%0d expected 0 0 0 0 count=%0d",
                     busy, force_req, done, abort, count, mq.size());
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && mq.size() > 0; i++) serve($urandom_range(0, TIMEOUT + 1), 0);
        n_checks++;
        if (empty !== 1'b1 || count !== 4'd0) begin
            n_fail++; $display("FAIL drain: empty=%b count=%0d expected 1 0", empty, count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; push = 1'b1; push_rw = 1'b1; push_addr = 32'hdead_beef;
        push_data = 32'h1234_5678; push_be = 4'hf;
        grant = 1'b0; devsel = 1'b0; tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
            n_fail++; $display("FAIL reset_queue: count=%0d empty=%b full=%b expected 0 1 0", count, empty, full);
        end
        n_checks++;
        if ({force_req, busy, done, abort} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: fr/busy/done/abort=%b expected 0000", {force_req, busy, done, abort});
        end
        n_checks++;
        if ({rw, contact_address, data, be} !== 69'd0) begin
            n_fail++; $display("FAIL reset_head: got %h expected 0", {rw, contact_address, data, be});
        end
        push = 1'b0; rst = 1'b0;
        grant = 1'b1; devsel = 1'b1; tready = 1'b1;
        mq.delete();
        tick(1'b0, 1'b0, rand_ent());
        n_checks++;
        if (empty !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_push_priority: empty=%b busy=%b expected 1 0", empty, busy);
        end
    endtask

    task automatic test_latency();
        ent_t e;
        e.rw = 1'b1; e.addr = 32'd20; e.data = 32'h7667_7667; e.be = 4'b1000;
        do_reset();
        grant = 1'b0; devsel = 1'b0; tready = 1'b0;
        tick(1'b1, 1'b0, e);
        n_checks++;
        if (count !== 4'd1 || force_req !== 1'b0) begin
            n_fail++; $display("FAIL lat_n: count=%0d fr=%b expected 1 0", count, force_req);
        end
        tick(1'b0, 1'b0, e);
        n_checks++;
        if (force_req !== 1'b0 || busy !== 1'b1 || rw !== 1'b1 || contact_address !== 32'd20) begin
            n_fail++; $display("FAIL lat_n1: fr=%b busy=%b rw=%b addr=%0d expected 0 1 1 20",
                               force_req, busy, rw, contact_address);
        end
        tick(1'b0, 1'b0, e);
        n_checks++;
        if (force_req !== 1'b1) begin
            n_fail++; $display("FAIL lat_n2: fr=%b expected 1", force_req);
        end
        tick(1'b0, 1'b0, e);
        n_checks++;
        if (force_req !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL lat_n3: fr=%b done=%b expected 1 0", force_req, done);
        end
        tick(1'b0, 1'b1, e);
        n_checks++;
        if (done !== 1'b1 || abort !== 1'b0 || empty !== 1'b1 || count !== 4'd0 || force_req !== 1'b0) begin
            n_fail++; $display("FAIL lat_n4: done=%b abort=%b empty=%b count=%0d fr=%b expected 1 0 1 0 0",
                               done, abort, empty, count, force_req);
        end
        tick(1'b0, 1'b0, e);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || data !== 32'h7667_7667 || be !== 4'b1000) begin
            n_fail++; $display("FAIL lat_n5: done=%b busy=%b data=%h be=%b expected 0 0 76677667 1000",
                               done, busy, data, be);
        end
        grant = 1'b1; devsel = 1'b1; tready = 1'b1;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            tick(1'b1, 1'b0, rand_ent());
            n_checks++;
            if (count !== 4'(mq.size()) || full !== (i >= DEPTH) || count !== 4'((i < DEPTH) ? i : DEPTH)) begin
                n_fail++; $display("FAIL fill_%0d: count=%0d full=%b expected %0d %b",
                                   i, count, full, (i < DEPTH) ? i : DEPTH, i >= DEPTH);
            end
        end
        drain();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, rand_ent());
        serve(TIMEOUT + 1, 1);
        serve(TIMEOUT - 1, 1);
        serve(TIMEOUT, 1);
        serve(0, 1);
        for (int i = 0; i < 8 && mq.size() > 0; i++) serve($urandom_range(0, TIMEOUT + 3), 1);
        drain();
    endtask

    task automatic test_back_to_back_wrap();
        do_reset();
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b0, rand_ent());
        for (int i = 0; i < 3 * DEPTH; i++) begin
            serve($urandom_range(0, TIMEOUT - 1), 2);
            n_checks++;
            if (count !== 4'(DEPTH) || full !== 1'b1) begin
                n_fail++; $display("FAIL wrap_%0d: count=%0d full=%b expected %0d 1", i, count, full, DEPTH);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        bit got;
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, rand_ent());
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (force_req === 1'b1) begin got = 1'b1; break; end
            tick(1'b0, 1'b0, rand_ent());
        end
        grant = 1'b0;
        tick(1'b0, 1'b0, rand_ent());
        grant = 1'b1;
        n_checks++;
        if (!got || force_req !== 1'b1 || count !== 4'd3) begin
            n_fail++; $display("FAIL mid_setup: fr=%b count=%0d expected 1 3", force_req, count);
        end
        rst = 1'b1; push = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; push = 1'b0;
        mq.delete();
        n_checks++;
        if (count !== 4'd0 || empty !== 1'b1 || force_req !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || abort !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: count=%0d empty=%b fr=%b busy=%b done=%b abort=%b expected 0 1 0 0 0 0",
                               count, empty, force_req, busy, done, abort);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, rand_ent());
            n_checks++;
            if (done !== 1'b0 || abort !== 1'b0 || busy !== 1'b0 || count !== 4'd0) begin
                n_fail++; $display("FAIL mid_after_%0d: done=%b abort=%b busy=%b count=%0d expected 0 0 0 0",
                                   i, done, abort, busy, count);
            end
        end
    endtask

    task automatic test_alternate();
        ent_t e;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            e = rand_ent();
            e.rw   = (i % 2 == 0);
            e.addr = (i % 2 == 0) ? 32'd10 : 32'd20;
            tick(1'b1, 1'b0, e);
        end
        for (int i = 0; i < DEPTH; i++) serve($urandom_range(0, TIMEOUT + 1), 0);
        n_checks++;
        if (empty !== 1'b1) begin
            n_fail++; $display("FAIL alt_empty: empty=%b expected 1", empty);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_full();
        test_timeout();
        test_back_to_back_wrap();
        test_reset_mid();
        test_alternate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
